serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial addition controller that sequences a single 1-bit `full_adder` instance over WIDTH cycles to add two WIDTH-bit operands, LSB first. It sits between a requester (a test harness or a higher-level datapath) and the shared full-adder cell. It owns operand capture, the carry flop, the bit counter and the start/done handshake. The result is held stable until the next accepted start.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; must be at least 2.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an add; sampled on the rising edge while ready=1.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- c_in  input  1  initial carry; captured on the accepting edge.
- ready  output  1  high when a start will be accepted (state IDLE or DONE).
- busy  output  1  high while in state RUN.
- done  output  1  one-cycle pulse; marks sum, c_out and overflow as valid.
- sum  output  WIDTH  result bits.
- c_out  output  1  carry out of the MSB.
- overflow  output  1  two's-complement overflow, equal to (carry into MSB) XOR c_out.

## Operation
- Contains one `full_adder` instance.
  - Inputs: a_sh[0], b_sh[0] and the carry register.
  - Outputs: sum bit and next carry.
- State machine has three states: IDLE, RUN, DONE.
  - IDLE: if start=1, load a_sh←a, b_sh←b, carry←c_in and cnt←0, then go to RUN.
  - RUN, on every edge:
    - shift a_sh and b_sh right by 1;
    - shift the full-adder sum bit into sum_sh at the MSB end (sum_sh shifts right, new bit enters bit WIDTH-1);
    - carry←full-adder c_out;
    - cnt←cnt+1.
  - RUN, on the edge where cnt==WIDTH-1:
    - also record carry_msb_in←carry (the carry into the MSB);
    - go to DONE.
  - DONE: done=1 for this one cycle.
    - If start=1, accept new operands exactly as from IDLE and go to RUN.
    - Otherwise go to IDLE.
- Output mapping:
  - sum = sum_sh;
  - c_out = carry;
  - overflow = carry_msb_in XOR carry.
- Outputs are registered and change only on the final RUN edge or on reset.
  - They hold through IDLE and through the next RUN until that run completes.
- start is ignored while busy=1. There is no queueing.
- Operand inputs a, b and c_in are don't-care except on the accepting edge.
- cnt is $clog2(WIDTH) bits wide. It does not wrap during a run, because RUN exits at WIDTH-1.
- Arithmetic is unsigned modulo 2^WIDTH. Full result is {c_out, sum} = a + b + c_in.

## Timing
- Reset values (rst_n=0, asynchronous):
  - state=IDLE, ready=1, busy=0, done=0;
  - sum=0, c_out=0, overflow=0;
  - all internal shift registers, cnt and carry cleared.
- Reset mid-RUN aborts the operation immediately. No done pulse is produced. Outputs read 0.
- Release of rst_n takes effect on the next rising edge. A start on the first edge after release is accepted.
- Latency, with the start accepted on edge E0:
  - busy=1 from E0 through E0+WIDTH;
  - the last bit is processed on edge E0+WIDTH;
  - done=1 and results valid in the cycle following E0+WIDTH.
- Start-to-done is WIDTH+1 edges. The next start can be accepted on the same edge that ends DONE, which gives back-to-back throughput of one add per WIDTH+1 cycles.
- A start asserted together with done (state DONE) is accepted. done still pulses for exactly one cycle.
- ready = NOT busy, combinationally from state.

## Test plan
All scenarios use WIDTH=8.
- Reset then a=0x00, b=0x00, c_in=0, start pulse:
  - busy high for 8 cycles;
  - done pulses exactly 9 edges after the start edge;
  - sum=0x00, c_out=0, overflow=0.
- a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1, overflow=0.
- a=0x7F, b=0x01, c_in=0 -> sum=0x80, c_out=0, overflow=1.
- a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1, overflow=0.
- Start a=0x12, b=0x34. On the 3rd busy cycle, pulse start with a=0xAA, b=0x55.
  - Second start is ignored: sum=0x46, c_out=0.
  - Only one done pulse.
  - Then a start held high during DONE with a=0x01, b=0x01 is accepted back-to-back and yields sum=0x02.
- Start a=0xF0, b=0x0F, then drive rst_n low on the 4th busy cycle:
  - all outputs go to 0 asynchronously, no done pulse;
  - after release, ready=1 and a new add a=0x03, b=0x04 yields sum=0x07.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial adder controller. One 1-bit full_adder cell is stepped over WIDTH
// clock cycles, LSB first, to form {c_out, sum} = a + b + c_in. The controller
// owns operand capture, the running carry, the bit counter and the start/done
// handshake. Results are held stable until the next accepted add completes.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     begin an add; sampled on the rising edge while ready=1
//   a, b      WIDTH-bit operands, captured on the accepting edge
//   c_in      initial carry, captured on the accepting edge
//   ready     a start will be accepted (IDLE or DONE)
//   busy      an add is in progress (RUN)
//   done      one-cycle pulse marking sum/c_out/overflow as freshly valid
//   sum       WIDTH-bit result
//   c_out     carry out of the MSB
//   overflow  two's-complement overflow: carry into MSB XOR carry out
// -----------------------------------------------------------------------------

// Single-bit full adder cell shared by the serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] sum_sh_r;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_r;
    logic             carry_msb_in_r;

    // Output holding registers: these only move on the final RUN edge, so the
    // previous result stays visible while the next add is being computed.
    logic [WIDTH-1:0] sum_r;
    logic             c_out_r;
    logic             overflow_r;
    logic             done_r;

    logic             fa_sum_s;
    logic             fa_carry_s;
    logic [WIDTH-1:0] sum_next_s;
    logic             busy_s;

    full_adder u_fa (
        .a     (a_sh_r[0]),
        .b     (b_sh_r[0]),
        .c_in  (carry_r),
        .s     (fa_sum_s),
        .c_out (fa_carry_s)
    );

    // New sum bit enters at the MSB end as the partial sum shifts right.
    assign sum_next_s = {fa_sum_s, sum_sh_r[WIDTH-1:1]};

    // Handshake flags decode directly from the state register.
    assign busy_s   = (state_r == ST_RUN);
    assign busy     = busy_s;
    assign ready    = ~busy_s;
    assign done     = done_r;
    assign sum      = sum_r;
    assign c_out    = c_out_r;
    assign overflow = overflow_r;

    // Control FSM together with the serial datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            a_sh_r         <= '0;
            b_sh_r         <= '0;
            sum_sh_r       <= '0;
            cnt_r          <= '0;
            carry_r        <= 1'b0;
            carry_msb_in_r <= 1'b0;
            sum_r          <= '0;
            c_out_r        <= 1'b0;
            overflow_r     <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        carry_r <= c_in;
                        cnt_r   <= '0;
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
                    sum_sh_r <= sum_next_s;
                    carry_r  <= fa_carry_s;
                    cnt_r    <= cnt_r + CNT_ONE;
                    if (cnt_r == LAST_CNT) begin
                        // carry_r here is the carry entering the MSB position.
                        carry_msb_in_r <= carry_r;
                        sum_r          <= sum_next_s;
                        c_out_r        <= fa_carry_s;
                        overflow_r     <= carry_r ^ fa_carry_s;
                        done_r         <= 1'b1;
                        state_r        <= ST_DONE;
                    end else begin
                        done_r  <= 1'b0;
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Directed bench for serial_adder_ctrl (WIDTH=8). A transaction-level model
// (integer add plus a cycle countdown) predicts every output each cycle; a
// compare process checks the DUT against it on every falling edge. Directed
// scenarios additionally check hand-computed literal results and latencies.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: returns {overflow, c_out, sum} from plain integer arithmetic.
    function automatic logic [9:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic ci);
        logic [8:0] full;
        logic       ov;
        full = {1'b0, x} + {1'b0, y} + {8'd0, ci};
        ov   = (x[7] == y[7]) && (full[7] != x[7]);
        return {ov, full};
    endfunction

    // ---------------- transaction-level model ----------------
    int         m_left;       // RUN cycles still to go; 0 means ready
    logic       m_done;
    logic [7:0] m_sum;
    logic       m_cout;
    logic       m_ovf;
    logic [9:0] m_pending;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_done = 1'b0; m_sum = 8'h00; m_cout = 1'b0; m_ovf = 1'b0;
            m_pending = 10'd0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_sum  = m_pending[7:0];
                    m_cout = m_pending[8];
                    m_ovf  = m_pending[9];
                end
            end else if (start) begin
                m_pending = ref_add(a, b, c_in);
                m_left    = W;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy",     {31'd0, busy},     {31'd0, (m_left > 0)});
            check("ready",    {31'd0, ready},    {31'd0, (m_left == 0)});
            check("done",     {31'd0, done},     {31'd0, m_done});
            check("sum",      {24'd0, sum},      {24'd0, m_sum});
            check("c_out",    {31'd0, c_out},    {31'd0, m_cout});
            check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        end
    end

    // Issue one add and wait (bounded) for done; reports latency and busy cycles.
    task automatic run_add(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                           output int lat, output int bcnt);
        @(posedge clk); #2;
        start = 1'b1; a = ta; b = tbv; c_in = tc;
        @(posedge clk); #2;                  // accepting edge just passed
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
        lat = 0; bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (done) break;
        end
    endtask

    task automatic check_result(input string name, input logic [7:0] es, input logic ec, input logic eo);
        check({name, ".sum"}, {24'd0, sum}, {24'd0, es});
        check({name, ".c_out"}, {31'd0, c_out}, {31'd0, ec});
        check({name, ".ovf"}, {31'd0, overflow}, {31'd0, eo});
    endtask

    initial begin
        int lat, bcnt, dones;
        logic [9:0] r;

        // Watchdog so the run can never hang.
        fork
            begin
                #200000;
                $display("FAIL watchdog: simulation exceeded time limit");
                $fatal(1, "watchdog");
            end
        join_none

        // Pin the reference model to hand-computed values.
        r = ref_add(8'h7F, 8'h01, 1'b0); check("ref.7F+01", {22'd0, r}, {22'd0, 10'b10_1000_0000});
        r = ref_add(8'hFF, 8'hFF, 1'b1); check("ref.FF+FF+1", {22'd0, r}, {22'd0, 10'b01_1111_1111});

        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; c_in = 1'b0;
        repeat (2) @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        check("reset.ready", {31'd0, ready}, 32'd1);
        check("reset.busy",  {31'd0, busy},  32'd0);
        check("reset.sum",   {24'd0, sum},   32'd0);
        @(posedge clk); #2; rst_n = 1'b1;

        // 0 + 0: latency and busy length.
        run_add(8'h00, 8'h00, 1'b0, lat, bcnt);
        check("zero.latency", lat, 32'd9);
        check("zero.busy_cycles", bcnt, 32'd8);
        check_result("zero", 8'h00, 1'b0, 1'b0);

        run_add(8'hFF, 8'h01, 1'b0, lat, bcnt);
        check_result("ff_01", 8'h00, 1'b1, 1'b0);

        run_add(8'h7F, 8'h01, 1'b0, lat, bcnt);
        check_result("7f_01", 8'h80, 1'b0, 1'b1);

        run_add(8'hFF, 8'hFF, 1'b1, lat, bcnt);
        check_result("ff_ff_1", 8'hFF, 1'b1, 1'b0);

        // Start during busy is ignored; then back-to-back start from DONE.
        @(posedge clk); #2;
        start = 1'b1; a = 8'h12; b = 8'h34; c_in = 1'b0;
        @(posedge clk); #2; start = 1'b0;           // E0
        repeat (2) @(posedge clk);
        #2; start = 1'b1; a = 8'hAA; b = 8'h55;     // 3rd busy cycle
        @(posedge clk); #2; start = 1'b0;
        lat = 3; dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin dones++; break; end
        end
        check("ignore.latency", lat, 32'd9);
        check("ignore.dones", dones, 32'd1);
        check_result("ignore", 8'h46, 1'b0, 1'b0);
        start = 1'b1; a = 8'h01; b = 8'h01; c_in = 1'b0;  // held during DONE
        @(posedge clk); #2;
        start = 1'b0;
        check("b2b.busy", {31'd0, busy}, 32'd1);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
        check("b2b.latency", lat, 32'd9);
        check_result("b2b", 8'h02, 1'b0, 1'b0);

        // Reset mid-run aborts with outputs forced to zero.
        @(posedge clk); #2;
        start = 1'b1; a = 8'hF0; b = 8'h0F; c_in = 1'b0;
        @(posedge clk); #2; start = 1'b0;           // E0
        repeat (3) @(posedge clk);
        #2; rst_n = 1'b0;                           // 4th busy cycle
        #1;
        check("arst.sum",   {24'd0, sum},      32'd0);
        check("arst.c_out", {31'd0, c_out},    32'd0);
        check("arst.ovf",   {31'd0, overflow}, 32'd0);
        check("arst.busy",  {31'd0, busy},     32'd0);
        check("arst.done",  {31'd0, done},     32'd0);
        check("arst.ready", {31'd0, ready},    32'd1);
        repeat (2) @(posedge clk);
        #2; rst_n = 1'b1;
        #1;
        check("release.ready", {31'd0, ready}, 32'd1);
        run_add(8'h03, 8'h04, 1'b0, lat, bcnt);
        check("post_rst.latency", lat, 32'd9);
        check_result("post_rst", 8'h07, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
